// File: rtl/hdr_cdw_pkg.sv
// hdr_cdw_pkg
// Shared definitions for the HDR command descriptor writer: FSM state
// encoding, DWORD field bit positions, the protected dummy configuration
// location and the descriptor size.
package hdr_cdw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_VERIFY,
    ST_DONE
  } cdw_state_t;

  localparam int DESC_BYTES         = 8;
  localparam int DUMMY_BASE_DEFAULT = 450;
  localparam int DUMMY_BYTES        = 4;

  // DWORD0 field positions
  localparam int CMD_ATTR_LSB  = 0;
  localparam int TID_LSB       = 3;
  localparam int CMD_LSB       = 7;
  localparam int CP_BIT        = 15;
  localparam int DEV_INDEX_LSB = 16;
  localparam int DTT_LSB       = 23;
  localparam int MODE_LSB      = 26;
  localparam int RNW_BIT       = 29;
  localparam int WROC_BIT      = 30;
  localparam int TOC_BIT       = 31;

  // DWORD1 field positions
  localparam int DATA_LEN_LSB  = 16;

  typedef struct packed {
    logic [2:0]  cmd_attr;
    logic [3:0]  tid;
    logic [7:0]  cmd;
    logic        cp;
    logic [4:0]  dev_index;
    logic [2:0]  dtt;
    logic [2:0]  mode;
    logic        rnw;
    logic        wroc;
    logic        toc;
    logic [15:0] data_len;
  } cdw_fields_t;

endpackage

// File: rtl/hdr_cmd_desc_packer.sv
// hdr_cmd_desc_packer
// Purely combinational: packs the command fields into the 8-byte HDR
// configuration layout (DWORD0 = bytes 0..3, DWORD1 = bytes 4..7,
// little-endian, byte k in desc[8k+7:8k]).
// Ports:
//   fields  in   command fields
//   desc    out  packed descriptor, 64 bits
module hdr_cmd_desc_packer
  import hdr_cdw_pkg::*;
(
  input  cdw_fields_t                 fields,
  output logic [DESC_BYTES*8-1:0]     desc
);

  logic [31:0] dword0;
  logic [31:0] dword1;

  // Reserved bits DWORD0[22:21] and DWORD1[15:0] stay zero from the default.
  always_comb begin
    dword0 = '0;
    dword1 = '0;
    dword0[CMD_ATTR_LSB  +: 3] = fields.cmd_attr;
    dword0[TID_LSB       +: 4] = fields.tid;
    dword0[CMD_LSB       +: 8] = fields.cmd;
    dword0[CP_BIT]             = fields.cp;
    dword0[DEV_INDEX_LSB +: 5] = fields.dev_index;
    dword0[DTT_LSB       +: 3] = fields.dtt;
    dword0[MODE_LSB      +: 3] = fields.mode;
    dword0[RNW_BIT]            = fields.rnw;
    dword0[WROC_BIT]           = fields.wroc;
    dword0[TOC_BIT]            = fields.toc;
    dword1[DATA_LEN_LSB  +: 16] = fields.data_len;
    desc = {dword1, dword0};
  end

endmodule

// File: rtl/hdr_cmd_desc_writer.sv
// hdr_cmd_desc_writer
// Packs HDR command fields into an 8-byte descriptor and writes it into the
// register file at base..base+7 through the single-byte write port, after
// arbitrating with a req/gnt pair. Bad base addresses (0, past the end of
// the register file, or touching the protected dummy configuration) are
// rejected with a one-cycle err pulse.
// Optional macro CDW_READBACK_EN: after writing, the descriptor is read back
// and compared; a mismatch pulses err instead of done.
// Ports:
//   i_cdw_clk / i_cdw_rst_n    clock, synchronous active-low reset
//   i_cdw_start                descriptor write request (IDLE only)
//   i_cdw_base_addr            byte address of DWORD0 byte 0
//   i_cdw_CMD_ATTR..data_len   command fields
//   i_cdw_gnt / o_cdw_req      register file port arbitration
//   o_cdw_regf_*               register file byte port
//   i_cdw_regf_data_rd         registered read data (read-back only)
//   o_cdw_busy/done/err        status
module hdr_cmd_desc_writer
  import hdr_cdw_pkg::*;
#(
  parameter int ADDR       = 12,
  parameter int DEPTH      = 4096,
  parameter int DUMMY_BASE = DUMMY_BASE_DEFAULT
) (
  input  logic            i_cdw_clk,
  input  logic            i_cdw_rst_n,
  input  logic            i_cdw_start,
  input  logic [ADDR-1:0] i_cdw_base_addr,
  input  logic [2:0]      i_cdw_CMD_ATTR,
  input  logic [3:0]      i_cdw_TID,
  input  logic [7:0]      i_cdw_CMD,
  input  logic            i_cdw_CP,
  input  logic [4:0]      i_cdw_DEV_INDEX,
  input  logic [2:0]      i_cdw_DTT,
  input  logic [2:0]      i_cdw_MODE,
  input  logic            i_cdw_RnW,
  input  logic            i_cdw_WROC,
  input  logic            i_cdw_TOC,
  input  logic [15:0]     i_cdw_data_len,
  input  logic            i_cdw_gnt,
  input  logic [7:0]      i_cdw_regf_data_rd,
  output logic            o_cdw_req,
  output logic            o_cdw_regf_wr_en,
  output logic            o_cdw_regf_rd_en,
  output logic [ADDR-1:0] o_cdw_regf_addr,
  output logic [7:0]      o_cdw_regf_data_wr,
  output logic            o_cdw_busy,
  output logic            o_cdw_done,
  output logic            o_cdw_err
);

  localparam logic [ADDR:0] WIN_SPAN    = (ADDR+1)'(DESC_BYTES - 1);
  localparam logic [ADDR:0] LAST_ADDR   = (ADDR+1)'(DEPTH - 1);
  localparam logic [ADDR:0] DUMMY_FIRST = (ADDR+1)'(DUMMY_BASE);
  localparam logic [ADDR:0] DUMMY_LAST  = (ADDR+1)'(DUMMY_BASE + DUMMY_BYTES - 1);

  cdw_state_t                  state;
  cdw_fields_t                 in_fields;
  cdw_fields_t                 fields;
  logic [ADDR-1:0]             base;
  logic [3:0]                  idx;
  logic                        err_pulse;
  logic [DESC_BYTES*8-1:0]     desc;
  logic [ADDR:0]               win_lo;
  logic [ADDR:0]               win_hi;
  logic                        addr_bad;
  logic                        wr_en;
  logic                        rd_en;

  assign in_fields = '{cmd_attr: i_cdw_CMD_ATTR, tid: i_cdw_TID, cmd: i_cdw_CMD,
                       cp: i_cdw_CP, dev_index: i_cdw_DEV_INDEX, dtt: i_cdw_DTT,
                       mode: i_cdw_MODE, rnw: i_cdw_RnW, wroc: i_cdw_WROC,
                       toc: i_cdw_TOC, data_len: i_cdw_data_len};

  hdr_cmd_desc_packer u_packer (
    .fields (fields),
    .desc   (desc)
  );

  // Window check is done one bit wider than the address so base+7 cannot wrap.
  // Base 0 is refused because the register file clears base-1 every cycle.
  always_comb begin
    win_lo   = {1'b0, i_cdw_base_addr};
    win_hi   = win_lo + WIN_SPAN;
    addr_bad = (win_lo == '0) || (win_hi > LAST_ADDR) ||
               ((win_lo <= DUMMY_LAST) && (win_hi >= DUMMY_FIRST));
  end

  assign wr_en = (state == ST_WRITE) && i_cdw_gnt;

`ifdef CDW_READBACK_EN
  // Read data arrives one cycle after the strobe, so the compare uses the
  // byte index remembered from the previous cycle.
  logic       pending;
  logic [2:0] pidx;
  logic       mismatch;

  assign mismatch = (state == ST_VERIFY) && pending &&
                    (i_cdw_regf_data_rd != desc[{pidx, 3'b000} +: 8]);
  assign rd_en    = (state == ST_VERIFY) && i_cdw_gnt && !idx[3] && !mismatch;
`else
  logic unused_rd_data;
  assign unused_rd_data = ^i_cdw_regf_data_rd;
  assign rd_en = 1'b0;
`endif

  assign o_cdw_regf_wr_en   = wr_en;
  assign o_cdw_regf_rd_en   = rd_en;
  assign o_cdw_regf_addr    = (wr_en || rd_en) ? base + ADDR'(idx[2:0]) : '0;
  assign o_cdw_regf_data_wr = wr_en ? desc[{idx[2:0], 3'b000} +: 8] : 8'h00;
  assign o_cdw_req          = (state == ST_WRITE) || ((state == ST_VERIFY) && !idx[3]);
  assign o_cdw_busy         = (state != ST_IDLE);
  assign o_cdw_done         = (state == ST_DONE);
  assign o_cdw_err          = err_pulse;

  // Descriptor FSM. idx counts granted byte transfers in WRITE and VERIFY;
  // in VERIFY it runs to 8 so the last read's compare can still happen.
  always_ff @(posedge i_cdw_clk) begin
    if (!i_cdw_rst_n) begin
      state     <= ST_IDLE;
      base      <= '0;
      fields    <= '0;
      idx       <= '0;
      err_pulse <= 1'b0;
`ifdef CDW_READBACK_EN
      pending   <= 1'b0;
      pidx      <= '0;
`endif
    end else begin
      err_pulse <= 1'b0;
`ifdef CDW_READBACK_EN
      pending   <= rd_en;
      pidx      <= idx[2:0];
`endif
      case (state)
        ST_IDLE: begin
          if (i_cdw_start) begin
            if (addr_bad) begin
              err_pulse <= 1'b1;
            end else begin
              base   <= i_cdw_base_addr;
              fields <= in_fields;
              idx    <= '0;
              state  <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (i_cdw_gnt) begin
            if (idx[2:0] == 3'd7) begin
              idx <= '0;
`ifdef CDW_READBACK_EN
              state <= ST_VERIFY;
`else
              state <= ST_DONE;
`endif
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
`ifdef CDW_READBACK_EN
        ST_VERIFY: begin
          if (mismatch) begin
            err_pulse <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            if (rd_en) idx <= idx + 4'd1;
            if (pending && (pidx == 3'd7)) state <= ST_DONE;
          end
        end
`endif
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_cmd_desc_writer.sv
// tb_hdr_cmd_desc_writer
// Self-checking bench for hdr_cmd_desc_writer with a small register file
// model and an arithmetic reference model of the descriptor layout.
module tb_hdr_cmd_desc_writer;

`ifdef CDW_READBACK_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 9;
`endif

  typedef struct packed {
    logic [2:0]  attr;
    logic [3:0]  tid;
    logic [7:0]  cmd;
    logic        cp;
    logic [4:0]  dev;
    logic [2:0]  dtt;
    logic [2:0]  mode;
    logic        rnw;
    logic        wroc;
    logic        toc;
    logic [15:0] len;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] base_in = '0;
  desc_t       cur = '0;
  logic        gnt = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        req, wr_en, rd_en, busy, done, err;
  logic [11:0] regf_addr;
  logic [7:0]  data_wr;

  logic [7:0]  mem [0:4095];
  bit          corrupt_en = 1'b0;
  logic [11:0] corrupt_addr = '0;

  int checks = 0;
  int errors = 0;

  logic [11:0] wr_addr_q [$];
  logic [7:0]  wr_data_q [$];
  int done_cnt, done_cyc, err_cnt, err_cyc, busy_cnt, both_cnt;
  bit busy_at0, zero_after_rst;

  hdr_cmd_desc_writer dut (
    .i_cdw_clk          (clk),
    .i_cdw_rst_n        (rst_n),
    .i_cdw_start        (start),
    .i_cdw_base_addr    (base_in),
    .i_cdw_CMD_ATTR     (cur.attr),
    .i_cdw_TID          (cur.tid),
    .i_cdw_CMD          (cur.cmd),
    .i_cdw_CP           (cur.cp),
    .i_cdw_DEV_INDEX    (cur.dev),
    .i_cdw_DTT          (cur.dtt),
    .i_cdw_MODE         (cur.mode),
    .i_cdw_RnW          (cur.rnw),
    .i_cdw_WROC         (cur.wroc),
    .i_cdw_TOC          (cur.toc),
    .i_cdw_data_len     (cur.len),
    .i_cdw_gnt          (gnt),
    .i_cdw_regf_data_rd (rd_data),
    .o_cdw_req          (req),
    .o_cdw_regf_wr_en   (wr_en),
    .o_cdw_regf_rd_en   (rd_en),
    .o_cdw_regf_addr    (regf_addr),
    .o_cdw_regf_data_wr (data_wr),
    .o_cdw_busy         (busy),
    .o_cdw_done         (done),
    .o_cdw_err          (err)
  );

  initial forever #5 clk = ~clk;

  // Register file model: byte writes, registered byte reads, optional
  // corruption of one address on the read path.
  always @(posedge clk) begin
    if (wr_en) mem[regf_addr] <= data_wr;
    if (rd_en) rd_data <= mem[regf_addr] ^ ((corrupt_en && regf_addr == corrupt_addr) ? 8'hFF : 8'h00);
  end

  // Reference: descriptor as a 64-bit number built from weighted fields.
  function automatic logic [7:0] model_byte(input desc_t d, input int k);
    longint unsigned dw0, dw1, full;
    dw0 = 64'(d.attr) + 64'(d.tid) * 64'd8 + 64'(d.cmd) * 64'd128 +
          64'(d.cp) * 64'd32768 + 64'(d.dev) * 64'd65536 + 64'(d.dtt) * 64'd8388608 +
          64'(d.mode) * 64'd67108864 + 64'(d.rnw) * 64'd536870912 +
          64'(d.wroc) * 64'd1073741824 + 64'(d.toc) * 64'd2147483648;
    dw1 = 64'(d.len) * 64'd65536;
    full = dw0 + dw1 * 64'd4294967296;
    return 8'((full >> (8 * k)) & 64'hFF);
  endfunction

  function automatic bit model_ok(input int b);
    return (b != 0) && (b + 7 <= 4095) && !((b <= 453) && (b + 7 >= 450));
  endfunction

  function automatic desc_t rand_desc();
    desc_t d;
    d.attr = 3'($urandom); d.tid = 4'($urandom); d.cmd = 8'($urandom);
    d.cp = 1'($urandom); d.dev = 5'($urandom); d.dtt = 3'($urandom);
    d.mode = 3'($urandom); d.rnw = 1'($urandom); d.wroc = 1'($urandom);
    d.toc = 1'($urandom); d.len = 16'($urandom);
    return d;
  endfunction

  // Issues one start in cycle 0 and records DUT activity for ncycles cycles.
  // Inputs are scrambled from cycle 1 on to confirm they were captured.
  task automatic drive_txn(input logic [11:0] b, input desc_t d, input int stall_lo,
                           input int stall_hi, input int gnt_pct, input int rst_cycle,
                           input bit restart, input int ncycles);
    wr_addr_q.delete(); wr_data_q.delete();
    done_cnt = 0; done_cyc = -1; err_cnt = 0; err_cyc = -1;
    busy_cnt = 0; both_cnt = 0; zero_after_rst = 1'b0;
    @(posedge clk); #1;
    base_in = b; cur = d; start = 1'b1; gnt = 1'b1;
    @(negedge clk);
    busy_at0 = busy;
    for (int c = 1; c <= ncycles; c++) begin
      @(posedge clk); #1;
      start = restart && (c == 3);
      cur = rand_desc();
      base_in = 12'($urandom_range(1, 4000));
      if (c >= stall_lo && c <= stall_hi) gnt = 1'b0;
      else gnt = ($urandom_range(0, 99) < gnt_pct);
      rst_n = (c != rst_cycle);
      @(negedge clk);
      if (wr_en) begin wr_addr_q.push_back(regf_addr); wr_data_q.push_back(data_wr); end
      if (wr_en && rd_en) both_cnt++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (err) begin err_cnt++; err_cyc = c; end
      if (busy) busy_cnt++;
      if (c == rst_cycle + 1)
        zero_after_rst = !req && !wr_en && !rd_en && regf_addr == 0 && data_wr == 0 &&
                         !busy && !done && !err;
    end
    start = 1'b0; gnt = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; gnt = 1'b1; base_in = 12'd1000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req, wr_en, rd_en} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_strobes got %b want 000", {req, wr_en, rd_en});
    end
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_status got %b want 000", {busy, done, err});
    end
    checks++;
    if (regf_addr !== 12'd0 || data_wr !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_bus got addr %0d data %h want 0 0", regf_addr, data_wr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b0; gnt = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_dummy_equiv();
    logic [7:0] exp [8] = '{8'h81, 8'h8F, 8'h00, 8'h18, 8'h00, 8'h00, 8'h04, 8'h00};
    desc_t d = '{attr: 3'd1, tid: 4'd0, cmd: 8'h1F, cp: 1'b1, dev: 5'd0, dtt: 3'd0,
                 mode: 3'd6, rnw: 1'b0, wroc: 1'b0, toc: 1'b0, len: 16'd4};
    drive_txn(12'd1000, d, 0, -1, 100, -10, 1'b0, LAT + 4);
    checks++;
    if (busy_at0 !== 1'b0) begin errors++; $display("[TB] FAIL dummy_busy_c0 got %b want 0", busy_at0); end
    checks++;
    if (wr_addr_q.size() != 8) begin errors++; $display("[TB] FAIL dummy_wr_count got %0d want 8", wr_addr_q.size()); end
    for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
      checks++;
      if (wr_addr_q[k] !== 12'(1000 + k) || wr_data_q[k] !== exp[k]) begin
        errors++;
        $display("[TB] FAIL dummy_byte%0d got %0d:%h want %0d:%h", k, wr_addr_q[k], wr_data_q[k], 1000 + k, exp[k]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != LAT) begin
      errors++; $display("[TB] FAIL dummy_done got count %0d cycle %0d want 1 %0d", done_cnt, done_cyc, LAT);
    end
    checks++;
    if (err_cnt != 0 || both_cnt != 0) begin
      errors++; $display("[TB] FAIL dummy_err_both got %0d %0d want 0 0", err_cnt, both_cnt);
    end
  endtask

  task automatic test_max_fields();
    logic [7:0] exp [8] = '{8'hFF, 8'hFF, 8'h9F, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};
    desc_t d = '{attr: 3'd7, tid: 4'hF, cmd: 8'hFF, cp: 1'b1, dev: 5'h1F, dtt: 3'd7,
                 mode: 3'd7, rnw: 1'b1, wroc: 1'b1, toc: 1'b1, len: 16'hFFFF};
    drive_txn(12'd2000, d, 0, -1, 100, -10, 1'b0, LAT + 4);
    checks++;
    if (wr_addr_q.size() != 8) begin errors++; $display("[TB] FAIL max_wr_count got %0d want 8", wr_addr_q.size()); end
    for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
      checks++;
      if (wr_addr_q[k] !== 12'(2000 + k) || wr_data_q[k] !== exp[k]) begin
        errors++;
        $display("[TB] FAIL max_byte%0d got %0d:%h want %0d:%h", k, wr_addr_q[k], wr_data_q[k], 2000 + k, exp[k]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != LAT) begin
      errors++; $display("[TB] FAIL max_done got count %0d cycle %0d want 1 %0d", done_cnt, done_cyc, LAT);
    end
  endtask

  task automatic test_grant_stall();
    desc_t d = rand_desc();
    drive_txn(12'd1500, d, 3, 5, 100, -10, 1'b0, LAT + 8);
    checks++;
    if (wr_addr_q.size() != 8) begin errors++; $display("[TB] FAIL stall_wr_count got %0d want 8", wr_addr_q.size()); end
    for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
      checks++;
      if (wr_addr_q[k] !== 12'(1500 + k) || wr_data_q[k] !== model_byte(d, k)) begin
        errors++;
        $display("[TB] FAIL stall_byte%0d got %0d:%h want %0d:%h", k, wr_addr_q[k], wr_data_q[k], 1500 + k, model_byte(d, k));
      end
    end
    checks++;
    if (done_cnt != 1 || done_cyc != LAT + 3) begin
      errors++; $display("[TB] FAIL stall_done got count %0d cycle %0d want 1 %0d", done_cnt, done_cyc, LAT + 3);
    end
  endtask

  task automatic test_rejections();
    int bases [6] = '{0, 4090, 447, 443, 4089, 453};
    foreach (bases[i]) begin
      drive_txn(12'(bases[i]), rand_desc(), 0, -1, 100, -10, 1'b0, 4);
      checks++;
      if (err_cnt != 1 || err_cyc != 1 || wr_addr_q.size() != 0 || busy_cnt != 0 || done_cnt != 0) begin
        errors++;
        $display("[TB] FAIL reject_base%0d got err %0d@%0d wr %0d busy %0d done %0d want 1@1 0 0 0",
                 bases[i], err_cnt, err_cyc, wr_addr_q.size(), busy_cnt, done_cnt);
      end
    end
  endtask

  task automatic test_start_while_busy();
    desc_t d = rand_desc();
    drive_txn(12'd1200, d, 0, -1, 100, -10, 1'b1, LAT + 6);
    checks++;
    if (wr_addr_q.size() != 8 || done_cnt != 1 || done_cyc != LAT) begin
      errors++;
      $display("[TB] FAIL busy_restart got wr %0d done %0d@%0d want 8 1@%0d", wr_addr_q.size(), done_cnt, done_cyc, LAT);
    end
    for (int k = 0; k < 8 && k < wr_addr_q.size(); k++) begin
      checks++;
      if (wr_addr_q[k] !== 12'(1200 + k) || wr_data_q[k] !== model_byte(d, k)) begin
        errors++;
        $display("[TB] FAIL busy_byte%0d got %0d:%h want %0d:%h", k, wr_addr_q[k], wr_data_q[k], 1200 + k, model_byte(d, k));
      end
    end
  endtask

  task automatic test_reset_mid();
    desc_t d = rand_desc();
    for (int k = 0; k < 8; k++) mem[1000 + k] <= 8'h5A;
    @(posedge clk);
    drive_txn(12'd1000, d, 0, -1, 100, 4, 1'b0, 8);
    checks++;
    if (!zero_after_rst) begin errors++; $display("[TB] FAIL rstmid_outputs got nonzero want all 0"); end
    checks++;
    if (wr_addr_q.size() != 4 || done_cnt != 0) begin
      errors++; $display("[TB] FAIL rstmid_counts got wr %0d done %0d want 4 0", wr_addr_q.size(), done_cnt);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (mem[1000 + k] !== ((k < 4) ? model_byte(d, k) : 8'h5A)) begin
        errors++;
        $display("[TB] FAIL rstmid_mem%0d got %h want %h", 1000 + k, mem[1000 + k], (k < 4) ? model_byte(d, k) : 8'h5A);
      end
    end
    @(posedge clk);
  endtask

  task automatic test_random();
    int edges [10] = '{0, 1, 442, 443, 447, 453, 454, 4088, 4089, 4095};
    for (int i = 0; i < 24; i++) begin
      int    b;
      bit    ok;
      desc_t d = rand_desc();
      b  = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 9)] : int'($urandom_range(0, 4095));
      ok = model_ok(b);
      drive_txn(12'(b), d, 0, -1, int'($urandom_range(60, 100)), -10, 1'b0, 90);
      checks++;
      if (ok ? (wr_addr_q.size() != 8 || done_cnt != 1 || err_cnt != 0)
             : (wr_addr_q.size() != 0 || done_cnt != 0 || err_cnt != 1)) begin
        errors++;
        $display("[TB] FAIL rand%0d_base%0d got wr %0d done %0d err %0d want accept=%0d",
                 i, b, wr_addr_q.size(), done_cnt, err_cnt, ok);
      end
      for (int k = 0; k < wr_addr_q.size() && k < 8; k++) begin
        checks++;
        if (wr_addr_q[k] !== 12'(b + k) || wr_data_q[k] !== model_byte(d, k)) begin
          errors++;
          $display("[TB] FAIL rand%0d_byte%0d got %0d:%h want %0d:%h", i, k, wr_addr_q[k], wr_data_q[k], b + k, model_byte(d, k));
        end
      end
      checks++;
      if (both_cnt != 0) begin errors++; $display("[TB] FAIL rand%0d_wr_rd_both got %0d want 0", i, both_cnt); end
    end
  endtask

`ifdef CDW_READBACK_EN
  task automatic test_readback_mismatch();
    corrupt_en = 1'b1; corrupt_addr = 12'd1005;
    drive_txn(12'd1000, rand_desc(), 0, -1, 100, -10, 1'b0, 24);
    corrupt_en = 1'b0;
    checks++;
    if (err_cnt != 1 || err_cyc != 16 || done_cnt != 0 || wr_addr_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL readback_mismatch got err %0d@%0d done %0d wr %0d want 1@16 0 8",
               err_cnt, err_cyc, done_cnt, wr_addr_q.size());
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL readback_idle got busy %b want 0", busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_dummy_equiv();
    test_max_fields();
    test_grant_stall();
    test_rejections();
    test_start_while_busy();
    test_reset_mid();
    test_random();
`ifdef CDW_READBACK_EN
    test_readback_mismatch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
